ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its `EX_*` outputs. It computes the single-cycle ALU result, and runs an iterative unsigned multiply/divide unit that stalls the front end while busy. It also contains the EX/MEM pipeline register that feeds the memory stage.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `MD_CYCLES`, 32, iterations of the multiply/divide engine. Must equal `XLEN`.

Ports (reset is asynchronous and active-high):
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `EX_pc4`  in  32  PC+4 of the instruction in EX.
- `EX_inst`  in  32  instruction word; rd = `EX_inst[11:7]`.
- `EX_wdsel`  in  2  write-back source select, passed through.
- `EX_rfwe`  in  1  register-file write enable.
- `EX_dmwe`  in  1  data-memory write enable.
- `EX_rfrD1`  in  32  operand A.
- `EX_rfrD2`  in  32  store data, passed through.
- `EX_alub`  in  32  operand B.
- `EX_aluop`  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
- `EX_md`  in  1  instruction is a multiply/divide op; overrides `EX_aluop`.
- `EX_mdop`  in  2  0 MUL (low 32), 1 MULHU, 2 DIVU, 3 REMU.
- `ex_stall`  out  1  holds PC, IF/ID and ID/EX.
- `MEM_pc4`, `MEM_wdsel`, `MEM_rfwe`, `MEM_dmwe`, `MEM_rd`[4:0], `MEM_alu`[31:0], `MEM_rfrD2`[31:0]  out  –  EX/MEM register outputs.

## Operation
- ALU operations:
  - ADD/SUB wrap modulo 2^32.
  - Shifts use `EX_alub[4:0]`.
  - SRA replicates `EX_rfrD1[31]`.
- Multiply/divide FSM states:
  - IDLE: if `EX_md`=1, latch A, B and `EX_mdop`, clear the counter, go to BUSY.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. After step `MD_CYCLES`-1, go to DONE.
  - DONE: result is valid; go to IDLE unconditionally.
- `ex_stall` = (IDLE and `EX_md`) or BUSY. It is combinational from state and `EX_md`.
- EX/MEM register:
  - While `ex_stall`=1, it captures a bubble: `MEM_rfwe`=0, `MEM_dmwe`=0, other fields don't-care.
  - Otherwise it captures the EX fields plus the result. The result is the md result in DONE, else the ALU result.
- Divide by zero: DIVU returns 0xFFFFFFFF and REMU returns the dividend. Both still take the full iteration count.
- MULHU returns the upper 32 bits of the 64-bit unsigned product.

## Timing
- Reset values: every MEM_* output is 0, FSM is in IDLE, counter is 0, `ex_stall`=0 unless `EX_md`=1.
- Non-md instruction: result appears on `MEM_alu` one edge after it is present on the `EX_*` inputs.
- md instruction:
  - `ex_stall` is high for 1 + `MD_CYCLES` = 33 cycles, then DONE for 1 cycle with stall low.
  - `MEM_alu` holds the result after the edge that ends DONE, 34 edges after the op first appears in EX.
- In DONE, `EX_md` is still 1 for the same instruction; it must not restart the FSM. Only IDLE samples `EX_md`.
- Back-to-back md ops: the second enters IDLE with `EX_md`=1 and stalls immediately. There is no gap cycle beyond DONE.
- Reset asserted mid-operation: immediately returns to IDLE and zeroes MEM_*. No partial result is written.

## Structure
- Shared package `ex_pkg`: ALU op codes, md op codes, FSM state enum, `XLEN`.
- One sub-module, `md_iter`: iterative multiply/divide engine with FSM, counter and operand/accumulator registers. Ports: start, op, a, b, busy, done, result.
- The ALU and the EX/MEM register stay in `ex_stage`.

## Test plan
- Reset: hold `rst`=1 with random inputs, then release. All MEM_* are 0, `ex_stall`=0, and FSM is in IDLE.
- ALU sweep:
  - A=0x80000000, B=0x00000004, ops 0–7.
  - Expected next-cycle `MEM_alu`: 0x80000004, 0x7FFFFFFC, 0, 0x80000004, 0x80000004, 0, 0x08000000, 0xF8000000.
- MUL/MULHU: A=0xFFFFFFFF, B=2.
  - MUL gives `MEM_alu`=0xFFFFFFFE; MULHU gives 1.
  - `ex_stall` high for exactly 33 cycles, and `MEM_rfwe`=0 during the stall.
- DIVU/REMU: A=100, B=7 gives 14 and 2. With B=0: DIVU gives 0xFFFFFFFF and REMU gives 100, same latency.
- Back-to-back MUL then DIVU, followed by an ADD:
  - Each md result lands exactly once.
  - The ADD reaches MEM one cycle after the second DONE.
- Assert `rst` in BUSY cycle 10: FSM returns to IDLE, MEM_* are 0, `ex_stall` follows `EX_md` after release.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU/md opcodes, md FSM states, EX/MEM record.
package ex_pkg;

  localparam int XLEN      = 32;
  localparam int MD_CYCLES = XLEN;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_MUL   = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [1:0]      wdsel;
    logic            rfwe;
    logic            dmwe;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rfrD2;
  } exmem_t;

  function automatic logic md_is_div(md_op_e op);
    return (op == MD_DIVU) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-facing inputs, stall back to the front end, and EX/MEM register outputs.
interface ex_stage_if;
  import ex_pkg::*;

  logic [XLEN-1:0] EX_pc4;
  logic [XLEN-1:0] EX_inst;
  logic [1:0]      EX_wdsel;
  logic            EX_rfwe;
  logic            EX_dmwe;
  logic [XLEN-1:0] EX_rfrD1;
  logic [XLEN-1:0] EX_rfrD2;
  logic [XLEN-1:0] EX_alub;
  logic [2:0]      EX_aluop;
  logic            EX_md;
  logic [1:0]      EX_mdop;

  logic            ex_stall;

  logic [XLEN-1:0] MEM_pc4;
  logic [1:0]      MEM_wdsel;
  logic            MEM_rfwe;
  logic            MEM_dmwe;
  logic [4:0]      MEM_rd;
  logic [XLEN-1:0] MEM_alu;
  logic [XLEN-1:0] MEM_rfrD2;

  modport master (
    output EX_pc4, EX_inst, EX_wdsel, EX_rfwe, EX_dmwe, EX_rfrD1, EX_rfrD2,
           EX_alub, EX_aluop, EX_md, EX_mdop,
    input  ex_stall,
    input  MEM_pc4, MEM_wdsel, MEM_rfwe, MEM_dmwe, MEM_rd, MEM_alu, MEM_rfrD2
  );

  modport slave (
    input  EX_pc4, EX_inst, EX_wdsel, EX_rfwe, EX_dmwe, EX_rfrD1, EX_rfrD2,
           EX_alub, EX_aluop, EX_md, EX_mdop,
    output ex_stall,
    output MEM_pc4, MEM_wdsel, MEM_rfwe, MEM_dmwe, MEM_rd, MEM_alu, MEM_rfrD2
  );

endinterface

// File: rtl/md_iter.sv
// Iterative unsigned multiply/divide: one shift-add or restoring-subtract step per BUSY cycle.
// Latency: 1 IDLE cycle + CYCLES BUSY cycles, result valid during the single DONE cycle.
module md_iter
  import ex_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(CYCLES);

  md_state_e        state, state_nxt;
  logic [CW-1:0]    cnt;
  md_op_e           op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             last_step;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;

  assign last_step = (cnt == CW'(CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Only IDLE looks at start, so a held request during DONE cannot relaunch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      MD_IDLE: if (start) state_nxt = MD_BUSY;
      MD_BUSY: begin
        busy = 1'b1;
        if (last_step) state_nxt = MD_DONE;
      end
      MD_DONE: begin
        done      = 1'b1;
        state_nxt = MD_IDLE;
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  // {hi,lo} is the product accumulator for multiply and {remainder,quotient} for divide.
  always_comb begin
    mul_sum  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    hi_nxt   = mul_sum[WIDTH:1];
    lo_nxt   = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (md_is_div(op_q)) begin
      if (!rem_diff[WIDTH]) begin
        hi_nxt = rem_diff[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      op_q <= MD_MUL;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == MD_IDLE && start) begin
      cnt  <= '0;
      op_q <= op;
      b_q  <= b;
      hi_q <= '0;
      lo_q <= a;
    end else if (state == MD_BUSY) begin
      cnt  <= cnt + 1'b1;
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
    end
  end

  always_comb begin
    result = lo_q;
    case (op_q)
      MD_MUL, MD_DIVU:  result = lo_q;
      MD_MULHU, MD_REMU: result = hi_q;
      default:          result = lo_q;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative md unit, and the EX/MEM pipeline register.
// ALU ops land in MEM one edge later; md ops stall the front end 33 cycles and land 34 edges later.
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);

  logic [XLEN-1:0] op_a, op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] md_res;
  logic            md_busy, md_done;
  logic            stall;
  ex_pkg::exmem_t  mem_q;
  logic            unused_inst_bits;

  assign op_a  = bus.EX_rfrD1;
  assign op_b  = bus.EX_alub;
  assign shamt = op_b[4:0];
  assign unused_inst_bits = ^{bus.EX_inst[31:12], bus.EX_inst[6:0]};

  always_comb begin
    alu_res = '0;
    case (ex_pkg::alu_op_e'(bus.EX_aluop))
      ex_pkg::ALU_ADD: alu_res = op_a + op_b;
      ex_pkg::ALU_SUB: alu_res = op_a - op_b;
      ex_pkg::ALU_AND: alu_res = op_a & op_b;
      ex_pkg::ALU_OR:  alu_res = op_a | op_b;
      ex_pkg::ALU_XOR: alu_res = op_a ^ op_b;
      ex_pkg::ALU_SLL: alu_res = op_a << shamt;
      ex_pkg::ALU_SRL: alu_res = op_a >> shamt;
      ex_pkg::ALU_SRA: alu_res = $signed(op_a) >>> shamt;
      default:         alu_res = '0;
    endcase
  end

  md_iter #(
    .WIDTH  (XLEN),
    .CYCLES (MD_CYCLES)
  ) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (bus.EX_md),
    .op     (ex_pkg::md_op_e'(bus.EX_mdop)),
    .a      (op_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );

  // Stall while a request waits in IDLE or the engine is iterating; DONE lets the op retire.
  assign stall        = (bus.EX_md & ~md_busy & ~md_done) | md_busy;
  assign bus.ex_stall = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q.pc4   <= bus.EX_pc4;
      mem_q.wdsel <= bus.EX_wdsel;
      mem_q.rfwe  <= bus.EX_rfwe & ~stall;
      mem_q.dmwe  <= bus.EX_dmwe & ~stall;
      mem_q.rd    <= bus.EX_inst[11:7];
      mem_q.alu   <= md_done ? md_res : alu_res;
      mem_q.rfrD2 <= bus.EX_rfrD2;
    end
  end

  assign bus.MEM_pc4   = mem_q.pc4;
  assign bus.MEM_wdsel = mem_q.wdsel;
  assign bus.MEM_rfwe  = mem_q.rfwe;
  assign bus.MEM_dmwe  = mem_q.dmwe;
  assign bus.MEM_rd    = mem_q.rd;
  assign bus.MEM_alu   = mem_q.alu;
  assign bus.MEM_rfrD2 = mem_q.rfrD2;

endmodule
